// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader and display driver side.
// Contents:
//   seg7_state_e   - reader FSM states (UNLOCKED is the reset state)
//   SEG_BLANK      - all-segments-off pattern
//   SEG_0 .. SEG_F - legal digit patterns, bit6..bit0 = g..a, active high
//   sat_inc8       - saturating 8-bit increment helper
package seg7_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SETTLING = 2'd1,
        LOCKED   = 2'd2
    } seg7_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Increment that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            return 8'hFF;
        end else begin
            return val + 8'd1;
        end
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from a seven-segment pattern to its hex value.
// Ports:
//   pattern - 7-bit segment pattern, bit0=a .. bit6=g
//   value   - decoded hex value (0 when illegal)
//   legal   - 1 when pattern is one of the 16 digit patterns
// Blank and every other pattern decode as illegal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       legal
);

    // Pattern table lookup.
    always_comb begin
        value = 4'h0;
        legal = 1'b1;
        case (pattern)
            SEG_0:   value = 4'h0;
            SEG_1:   value = 4'h1;
            SEG_2:   value = 4'h2;
            SEG_3:   value = 4'h3;
            SEG_4:   value = 4'h4;
            SEG_5:   value = 4'h5;
            SEG_6:   value = 4'h6;
            SEG_7:   value = 4'h7;
            SEG_8:   value = 4'h8;
            SEG_9:   value = 4'h9;
            SEG_A:   value = 4'hA;
            SEG_B:   value = 4'hB;
            SEG_C:   value = 4'hC;
            SEG_D:   value = 4'hD;
            SEG_E:   value = 4'hE;
            SEG_F:   value = 4'hF;
            default: begin
                value = 4'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Seven-segment display reader: synchronises asynchronous segment lines,
// waits for a pattern to be stable and reports the decoded hex digit.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset, overrides ena
//   ena         - block enable; when low the FSM/outputs hold, pulses are 0,
//                 the input synchroniser keeps running
//   seg_in      - asynchronous segment lines, bit0=a .. bit6=g
//   digit       - last accepted hex digit
//   digit_valid - digit matches the currently stable pattern
//   new_digit   - one-cycle pulse when a changed digit is accepted
//   err         - one-cycle pulse when a stable pattern is not a digit
//   change_cnt  - wrapping count of new_digit pulses
//   err_cnt     - saturating count of err pulses (only with the
//                 SEG7_READER_ERRCNT_EN macro defined)
// Parameter STABLE_CYCLES (2..255): stable samples needed for acceptance.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       new_digit,
    output logic       err,
    output logic [7:0] change_cnt
`ifdef SEG7_READER_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]  sync_meta_r;
    logic [6:0]  sync_r;
    logic [6:0]  prev_r;
    logic [6:0]  prev_s;
    seg7_state_e state_r;
    seg7_state_e state_s;
    logic [7:0]  stab_cnt_r;
    logic [7:0]  stab_cnt_s;
    logic [3:0]  digit_r;
    logic [3:0]  digit_s;
    logic        valid_r;
    logic        valid_s;
    logic        new_r;
    logic        new_s;
    logic        err_r;
    logic        err_s;
    logic [7:0]  chg_cnt_r;
    logic [7:0]  chg_cnt_s;
    logic        accepted_r;
    logic        accepted_s;
    logic [3:0]  dec_value_s;
    logic        dec_legal_s;

    seg7_pattern_decode u_decode (
        .pattern (sync_r),
        .value   (dec_value_s),
        .legal   (dec_legal_s)
    );

    // Next-state and output logic of the acceptance FSM.
    // accepted_r remembers that digit_r holds a real accepted value; it is
    // cleared only by reset or an illegal evaluation, so a brief glitch that
    // returns to the same digit does not produce a second new_digit pulse.
    always_comb begin
        prev_s     = prev_r;
        state_s    = state_r;
        stab_cnt_s = stab_cnt_r;
        digit_s    = digit_r;
        valid_s    = valid_r;
        new_s      = 1'b0;
        err_s      = 1'b0;
        chg_cnt_s  = chg_cnt_r;
        accepted_s = accepted_r;
        if (ena) begin
            prev_s = sync_r;
            if (sync_r != prev_r) begin
                // A change always restarts settling, even on an evaluation cycle.
                state_s    = SETTLING;
                stab_cnt_s = 8'd0;
                valid_s    = 1'b0;
            end else begin
                case (state_r)
                    SETTLING: begin
                        if (stab_cnt_r == CNT_LAST) begin
                            stab_cnt_s = 8'd0;
                            if (dec_legal_s) begin
                                state_s    = LOCKED;
                                digit_s    = dec_value_s;
                                valid_s    = 1'b1;
                                accepted_s = 1'b1;
                                if (!accepted_r || (dec_value_s != digit_r)) begin
                                    new_s     = 1'b1;
                                    chg_cnt_s = chg_cnt_r + 8'd1;
                                end else begin
                                    new_s     = 1'b0;
                                    chg_cnt_s = chg_cnt_r;
                                end
                            end else begin
                                state_s    = UNLOCKED;
                                err_s      = 1'b1;
                                valid_s    = 1'b0;
                                accepted_s = 1'b0;
                            end
                        end else begin
                            stab_cnt_s = stab_cnt_r + 8'd1;
                        end
                    end
                    UNLOCKED: state_s = UNLOCKED;
                    LOCKED:   state_s = LOCKED;
                    default: begin
                        state_s    = UNLOCKED;
                        stab_cnt_s = 8'd0;
                        valid_s    = 1'b0;
                    end
                endcase
            end
        end else begin
            prev_s = prev_r;
        end
    end

    // Synchroniser and FSM/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_r <= SEG_BLANK;
            sync_r      <= SEG_BLANK;
            prev_r      <= SEG_BLANK;
            state_r     <= UNLOCKED;
            stab_cnt_r  <= 8'd0;
            digit_r     <= 4'h0;
            valid_r     <= 1'b0;
            new_r       <= 1'b0;
            err_r       <= 1'b0;
            chg_cnt_r   <= 8'd0;
            accepted_r  <= 1'b0;
        end else begin
            sync_meta_r <= seg_in;
            sync_r      <= sync_meta_r;
            prev_r      <= prev_s;
            state_r     <= state_s;
            stab_cnt_r  <= stab_cnt_s;
            digit_r     <= digit_s;
            valid_r     <= valid_s;
            new_r       <= new_s;
            err_r       <= err_s;
            chg_cnt_r   <= chg_cnt_s;
            accepted_r  <= accepted_s;
        end
    end

    assign digit       = digit_r;
    assign digit_valid = valid_r;
    assign new_digit   = new_r;
    assign err         = err_r;
    assign change_cnt  = chg_cnt_r;

`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0] err_cnt_r;
    logic [7:0] err_cnt_s;

    // Saturating error counter next value.
    always_comb begin
        err_cnt_s = err_cnt_r;
        if (err_s) begin
            err_cnt_s = sat_inc8(err_cnt_r);
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else begin
            err_cnt_r <= err_cnt_s;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule
